// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V subset control unit (Moore FSM with a few input-qualified outputs).
//
// Sequences the shared-memory multi-cycle datapath through fetch, decode, address
// generation, memory access, execute, write-back, branch and (optionally) jal states.
// Unsupported encodings and memory stalls that exceed WAIT_LIMIT park the FSM in TRAP
// until reset.
//
// Optional feature: define MULTICYCLE_JAL_EN to add the JAL state and jal decoding.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   zero               ALU zero flag (branch resolution)
//   mem_ready          memory access completes this cycle
//   op/funct3/funct7_5 instruction fields from the instruction register
//   pc_write, adr_src, ir_write, mem_req, mem_write, reg_write   datapath enables/selects
//   result_src, alu_src_a, alu_src_b, imm_src                     datapath mux selects
//   alu_control        ALU operation (bits above 2 tied to 0)
//   illegal            high while in TRAP
module multicycle_control #(
  parameter int unsigned ALUC_W     = 3,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              zero,
  input  logic              mem_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  output logic              pc_write,
  output logic              adr_src,
  output logic              ir_write,
  output logic              mem_req,
  output logic              mem_write,
  output logic              reg_write,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        imm_src,
  output logic [ALUC_W-1:0] alu_control,
  output logic              illegal
);

  localparam int unsigned CntW = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntLimit = CntW'(WAIT_LIMIT);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;
  localparam logic [2:0] AluSra = 3'b110;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StTrap
`ifdef MULTICYCLE_JAL_EN
    , StJal
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;

  logic [2:0] alu_op;
  logic [2:0] exec_alu;
  logic       exec_legal;
  logic       br_legal;
  logic       br_taken;
  logic       mem_state;
  logic       timeout;

  // Execute-stage ALU decode, shared by EXECR and EXECI. op[5] separates R-type from
  // I-type so that addi never becomes a subtract.
  always_comb begin
    exec_alu   = AluAdd;
    exec_legal = 1'b1;
    case (funct3)
      3'b000:  exec_alu = (op[5] && funct7_5) ? AluSub : AluAdd;
      3'b010:  exec_alu = AluSlt;
      3'b110:  exec_alu = AluOr;
      3'b111:  exec_alu = AluAnd;
      3'b101: begin
        if (funct7_5) begin
          exec_alu = AluSra;
        end else begin
          exec_legal = 1'b0;
        end
      end
      default: exec_legal = 1'b0;
    endcase
  end

  assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  // Stall watchdog: mem_ready in the limit cycle wins over the timeout.
  assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign timeout   = (WAIT_LIMIT != 0) && mem_state && (wait_q == CntLimit) && !mem_ready;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = AluAdd;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
`ifdef MULTICYCLE_JAL_EN
          OpJal:           state_d = StJal;
`endif
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // Only lw/sw reach here; op[5] distinguishes them.
        state_d   = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = exec_alu;
        state_d   = exec_legal ? StAluWb : StTrap;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = exec_alu;
        state_d   = exec_legal ? StAluWb : StTrap;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 2'b10;
        alu_op    = AluSub;
        pc_write  = br_taken;
        state_d   = br_legal ? StFetch : StTrap;
      end
`ifdef MULTICYCLE_JAL_EN
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
`endif
      StTrap: begin
        illegal = 1'b1;
      end
      default: state_d = StTrap;
    endcase
  end

  // Consecutive not-ready cycles in the current memory state; saturates rather than wraps.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_state && !mem_ready && (wait_q != CntMax)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OpStore:  imm_src = 2'b01;
      OpBranch: imm_src = 2'b10;
`ifdef MULTICYCLE_JAL_EN
      OpJal:    imm_src = 2'b11;
`endif
      default:  imm_src = 2'b00;
    endcase
  end

  assign alu_control = ALUC_W'(alu_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (ALUC_W=4, WAIT_LIMIT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_multicycle_control;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;

  logic       pc_write, adr_src, ir_write, mem_req, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_control;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .ALUC_W     (4),
    .WAIT_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  logic [16:0] outv;
  assign outv = {pc_write, adr_src, ir_write, mem_req, mem_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_control, illegal};

  function automatic logic [16:0] ov(input logic pcw, input logic adr, input logic irw,
                                     input logic mreq, input logic mw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [3:0] ac,
                                     input logic ill);
    return {pcw, adr, irw, mreq, mw, rw, rs, sa, sb, ac, ill};
  endfunction

  // Expected per-state output words.
  function automatic logic [16:0] o_fetch(input logic rdy);
    return ov(rdy, 1'b0, rdy, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 4'd0, 1'b0);
  endfunction
  function automatic logic [16:0] o_decode();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'd0, 1'b0);
  endfunction
  function automatic logic [16:0] o_memadr();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'd0, 1'b0);
  endfunction
  function automatic logic [16:0] o_memread();
    return ov(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [16:0] o_memwb();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [16:0] o_memwrite();
    return ov(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [16:0] o_execr(input logic [3:0] ac);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, ac, 1'b0);
  endfunction
  function automatic logic [16:0] o_execi(input logic [3:0] ac);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, ac, 1'b0);
  endfunction
  function automatic logic [16:0] o_aluwb();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0);
  endfunction
  function automatic logic [16:0] o_branch(input logic pcw);
    return ov(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'd1, 1'b0);
  endfunction
  function automatic logic [16:0] o_jal();
    return ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 4'd0, 1'b0);
  endfunction
  function automatic logic [16:0] o_trap();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 1'b1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the outputs of the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [16:0] exp);
    @(negedge clk);
    check(tag, 32'(outv), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc("reset_outputs", o_fetch(mem_ready));
    rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7_5 = f7;
  endtask

  initial begin
    // Reset state, then stall timeout: 5 FETCH cycles with mem_ready=0, then TRAP.
    cyc("reset_fetch", o_fetch(1'b0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc("timeout_fetch", o_fetch(1'b0));
    cyc("timeout_trap", o_trap());
    mem_ready = 1'b1;
    cyc("trap_hold", o_trap());
    do_reset();

    // lw, always ready.
    set_instr(OpLoad, 3'b010, 1'b0);
    cyc("lw_fetch", o_fetch(1'b1));
    check("lw_imm", 32'(imm_src), 32'd0);
    cyc("lw_decode", o_decode());
    cyc("lw_memadr", o_memadr());
    cyc("lw_memread", o_memread());
    cyc("lw_memwb", o_memwb());

    // lw with 4 stalls in MEMREAD; ready arrives exactly at the limit and wins.
    cyc("lw2_fetch", o_fetch(1'b1));
    cyc("lw2_decode", o_decode());
    cyc("lw2_memadr", o_memadr());
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("lw2_memread_wait", o_memread());
    mem_ready = 1'b1;
    cyc("lw2_memread_limit", o_memread());
    cyc("lw2_memwb", o_memwb());

    // sw with 3 stall cycles: mem_write high for 4 cycles, then FETCH.
    set_instr(OpStore, 3'b010, 1'b0);
    cyc("sw_fetch", o_fetch(1'b1));
    check("sw_imm", 32'(imm_src), 32'd1);
    cyc("sw_decode", o_decode());
    cyc("sw_memadr", o_memadr());
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sw_memwrite_wait", o_memwrite());
    mem_ready = 1'b1;
    cyc("sw_memwrite_done", o_memwrite());

    // beq taken, bne not taken (zero=1 for both).
    zero = 1'b1;
    set_instr(OpBranch, 3'b000, 1'b0);
    cyc("beq_fetch", o_fetch(1'b1));
    check("beq_imm", 32'(imm_src), 32'd2);
    cyc("beq_decode", o_decode());
    cyc("beq_branch", o_branch(1'b1));
    set_instr(OpBranch, 3'b001, 1'b0);
    cyc("bne_fetch", o_fetch(1'b1));
    cyc("bne_decode", o_decode());
    cyc("bne_branch", o_branch(1'b0));
    zero = 1'b0;

    // R-type sub and I-type addi with funct7_5=1.
    set_instr(OpRtype, 3'b000, 1'b1);
    cyc("sub_fetch", o_fetch(1'b1));
    check("rtype_imm", 32'(imm_src), 32'd0);
    cyc("sub_decode", o_decode());
    cyc("sub_execr", o_execr(4'b0001));
    cyc("sub_aluwb", o_aluwb());
    set_instr(OpItype, 3'b000, 1'b1);
    cyc("addi_fetch", o_fetch(1'b1));
    cyc("addi_decode", o_decode());
    cyc("addi_execi", o_execi(4'b0000));
    cyc("addi_aluwb", o_aluwb());

    // Remaining ALU encodings.
    set_instr(OpRtype, 3'b111, 1'b0);
    cyc("and_fetch", o_fetch(1'b1));
    cyc("and_decode", o_decode());
    cyc("and_execr", o_execr(4'b0010));
    cyc("and_aluwb", o_aluwb());
    set_instr(OpRtype, 3'b110, 1'b0);
    cyc("or_fetch", o_fetch(1'b1));
    cyc("or_decode", o_decode());
    cyc("or_execr", o_execr(4'b0011));
    cyc("or_aluwb", o_aluwb());
    set_instr(OpItype, 3'b010, 1'b0);
    cyc("slti_fetch", o_fetch(1'b1));
    cyc("slti_decode", o_decode());
    cyc("slti_execi", o_execi(4'b0101));
    cyc("slti_aluwb", o_aluwb());
    set_instr(OpItype, 3'b101, 1'b1);
    cyc("srai_fetch", o_fetch(1'b1));
    cyc("srai_decode", o_decode());
    cyc("srai_execi", o_execi(4'b0110));
    cyc("srai_aluwb", o_aluwb());

    // srl (funct3=101, funct7_5=0) is unsupported: add in EXECR, then TRAP.
    set_instr(OpRtype, 3'b101, 1'b0);
    cyc("srl_fetch", o_fetch(1'b1));
    cyc("srl_decode", o_decode());
    cyc("srl_execr", o_execr(4'b0000));
    cyc("srl_trap", o_trap());
    do_reset();

    // Branch with funct3=100: no pc_write, then TRAP; reset clears illegal.
    zero = 1'b1;
    set_instr(OpBranch, 3'b100, 1'b0);
    cyc("brbad_fetch", o_fetch(1'b1));
    cyc("brbad_decode", o_decode());
    cyc("brbad_branch", o_branch(1'b0));
    cyc("brbad_trap", o_trap());
    cyc("brbad_trap_hold", o_trap());
    do_reset();
    zero = 1'b0;

    // Unknown opcode goes straight from DECODE to TRAP.
    set_instr(7'b0000000, 3'b000, 1'b0);
    cyc("badop_fetch", o_fetch(1'b1));
    cyc("badop_decode", o_decode());
    cyc("badop_trap", o_trap());
    do_reset();

    // jal: present only with the feature macro.
    set_instr(OpJal, 3'b000, 1'b0);
    cyc("jal_fetch", o_fetch(1'b1));
`ifdef MULTICYCLE_JAL_EN
    check("jal_imm", 32'(imm_src), 32'd3);
    cyc("jal_decode", o_decode());
    cyc("jal_jal", o_jal());
    cyc("jal_aluwb", o_aluwb());
`else
    check("jal_imm", 32'(imm_src), 32'd0);
    cyc("jal_decode", o_decode());
    cyc("jal_trap", o_trap());
    do_reset();
`endif
    set_instr(OpLoad, 3'b010, 1'b0);
    cyc("final_fetch", o_fetch(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
